// File: rtl/fe_pipe_pkg.sv
// ---------------------------------------------------------------------------
// fe_pipe_pkg
//
// Shared definitions for the front-end pipe buffers (fetch/decode/rename).
//
// Contents:
//   STAT_W        width of the statistics counters exported by pipe buffers
//   FE_BUF_DEPTH  default number of entries in a front-end pipe buffer
//   fe_payload_t  default payload carried between front-end stages
//                 (32-bit instruction word plus 9-bit PC tag = 41 bits)
// ---------------------------------------------------------------------------
package fe_pipe_pkg;

   localparam int STAT_W       = 16;
   localparam int FE_BUF_DEPTH = 4;

   typedef struct packed {
      logic [31:0] instr;
      logic [8:0]  pc;
   } fe_payload_t;

endpackage : fe_pipe_pkg

// File: rtl/flush_pipe_buffer.sv
// ---------------------------------------------------------------------------
// flush_pipe_buffer
//
// Elastic valid/ready FIFO placed between front-end stages.  It carries an
// opaque payload, supports a synchronous flush for branch-mispredict
// recovery, and exports its occupancy so upstream stages can throttle.
//
// Parameters:
//   DWIDTH  payload width in bits (default: width of fe_payload_t, 41)
//   DEPTH   number of entries, power of two and >= 2 (default FE_BUF_DEPTH)
//   CNTW    occupancy counter width, derived from DEPTH
//
// Ports:
//   clk          clock
//   reset        asynchronous active-high reset
//   i_data       upstream payload
//   i_valid      upstream payload valid
//   o_ready      buffer can accept this cycle (independent of i_ready)
//   o_data       head-entry payload (don't-care while o_valid=0)
//   o_valid      head entry valid
//   i_ready      downstream accepts head
//   i_flush      discard all entries; blocks both handshakes that cycle
//   o_count      current occupancy, 0..DEPTH
//   o_stall_cnt  saturating count of upstream stall cycles
//
// Build option:
//   FLUSH_PIPE_BUFFER_STATS_EN  when defined, o_stall_cnt counts cycles in
//                               which upstream offers data but the buffer is
//                               full; when undefined the port is tied to 0.
// ---------------------------------------------------------------------------
module flush_pipe_buffer
   import fe_pipe_pkg::*;
#(
   parameter  int DWIDTH = $bits(fe_payload_t),
   parameter  int DEPTH  = FE_BUF_DEPTH,
   localparam int CNTW   = $clog2(DEPTH + 1)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DWIDTH-1:0] i_data,
   input  logic              i_valid,
   output logic              o_ready,
   output logic [DWIDTH-1:0] o_data,
   output logic              o_valid,
   input  logic              i_ready,
   input  logic              i_flush,
   output logic [CNTW-1:0]   o_count,
   output logic [STAT_W-1:0] o_stall_cnt
);

   localparam int PTRW = $clog2(DEPTH);

   logic [DWIDTH-1:0] mem [DEPTH];
   logic [PTRW-1:0]   wr_ptr;
   logic [PTRW-1:0]   rd_ptr;
   logic [CNTW-1:0]   count;
   logic              push;
   logic              pop;

   // Handshake qualifiers.  Full and empty come from the occupancy counter
   // alone, so the pointers are free to wrap.  o_ready looks only at local
   // state and the flush, never at i_ready, which keeps the ready path from
   // chaining through this stage; as a consequence a full buffer refuses a
   // push even when it is popping in the same cycle.
   always_comb begin
      o_ready = (count != CNTW'(DEPTH)) && !i_flush;
      o_valid = (count != '0) && !i_flush;
      push    = i_valid && o_ready;
      pop     = o_valid && i_ready;
   end

   assign o_data  = mem[rd_ptr];
   assign o_count = count;

   // Storage is written only on an accepted push; it is deliberately left
   // out of reset since count gates every read of it.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= i_data;
      end
   end

   // Pointer and occupancy state.  Flush wins over everything and returns
   // the buffer to its post-reset state on the next edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (i_flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PTRW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTRW'(1);
         end
         case ({push, pop})
            2'b10:   count <= count + CNTW'(1);
            2'b01:   count <= count - CNTW'(1);
            default: count <= count;
         endcase
      end
   end

`ifdef FLUSH_PIPE_BUFFER_STATS_EN
   logic [STAT_W-1:0] stall_cnt;
   logic              stall;

   // A stall is a cycle where upstream has data but the buffer is full.
   // Flush cycles are excluded since o_ready is forced low for a different
   // reason.  The counter survives flushes and saturates at all-ones.
   assign stall = i_valid && !o_ready && !i_flush;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stall_cnt <= '0;
      end else if (stall && (stall_cnt != '1)) begin
         stall_cnt <= stall_cnt + STAT_W'(1);
      end
   end

   assign o_stall_cnt = stall_cnt;
`else
   assign o_stall_cnt = '0;
`endif

endmodule : flush_pipe_buffer

// File: tb/tb_flush_pipe_buffer.sv
// ---------------------------------------------------------------------------
// tb_flush_pipe_buffer
//
// Self-checking bench for flush_pipe_buffer.  A queue-based reference model
// tracks the expected contents, handshakes and stall count; directed steps
// cover reset, fill/drain, streaming, full-with-pop, flush and the stall
// counter, followed by a randomized phase.
// ---------------------------------------------------------------------------
module tb_flush_pipe_buffer;
   import fe_pipe_pkg::*;

   localparam int DWIDTH = 41;
   localparam int DEPTH  = 4;
   localparam int CNTW   = $clog2(DEPTH + 1);

`ifdef FLUSH_PIPE_BUFFER_STATS_EN
   localparam bit STATS_EN = 1'b1;
`else
   localparam bit STATS_EN = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              reset;
   logic [DWIDTH-1:0] i_data;
   logic              i_valid;
   logic              o_ready;
   logic [DWIDTH-1:0] o_data;
   logic              o_valid;
   logic              i_ready;
   logic              i_flush;
   logic [CNTW-1:0]   o_count;
   logic [STAT_W-1:0] o_stall_cnt;

   logic [DWIDTH-1:0] model_q[$];
   logic [DWIDTH-1:0] recv_q[$];
   int unsigned       model_stall;
   int                pass_cnt = 0;
   int                check_cnt = 0;
   int                fail_cnt = 0;

   flush_pipe_buffer #(.DWIDTH(DWIDTH), .DEPTH(DEPTH)) dut (
      .clk         (clk),
      .reset       (reset),
      .i_data      (i_data),
      .i_valid     (i_valid),
      .o_ready     (o_ready),
      .o_data      (o_data),
      .o_valid     (o_valid),
      .i_ready     (i_ready),
      .i_flush     (i_flush),
      .o_count     (o_count),
      .o_stall_cnt (o_stall_cnt)
   );

   always #5 clk = ~clk;

   // Single comparison point: every check in the bench funnels through here.
   task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      check_cnt++;
      assert (obs === exp) pass_cnt++;
      else begin
         fail_cnt++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Expected outputs follow from the model occupancy and the current flush.
   task automatic checkOutput(input string tag);
      logic        exp_valid;
      logic        exp_ready;
      int unsigned exp_stall;
      exp_valid = (model_q.size() != 0) && !i_flush;
      exp_ready = (model_q.size() != DEPTH) && !i_flush;
      exp_stall = STATS_EN ? model_stall : 0;
      checkVal({tag, ".valid"}, 64'(o_valid), 64'(exp_valid));
      checkVal({tag, ".ready"}, 64'(o_ready), 64'(exp_ready));
      checkVal({tag, ".count"}, 64'(o_count), 64'(model_q.size()));
      if (exp_valid) begin
         checkVal({tag, ".data"}, 64'(o_data), 64'(model_q[0]));
      end
      checkVal({tag, ".stall"}, 64'(o_stall_cnt), 64'(exp_stall));
   endtask

   // Drive one cycle: check outputs mid-cycle, then advance the model on the
   // rising edge using the same inputs the DUT sampled.
   task automatic applyStimulus(input logic v, input logic [DWIDTH-1:0] d,
                                input logic r, input logic f, input string tag);
      logic exp_valid;
      logic exp_ready;
      i_valid = v;
      i_data  = d;
      i_ready = r;
      i_flush = f;
      @(negedge clk);
      checkOutput(tag);
      @(posedge clk);
      exp_valid = (model_q.size() != 0) && !f;
      exp_ready = (model_q.size() != DEPTH) && !f;
      if (f) begin
         model_q.delete();
      end else begin
         if (exp_valid && r) begin
            recv_q.push_back(model_q.pop_front());
         end
         if (exp_ready && v) begin
            model_q.push_back(d);
         end
      end
      if (v && !exp_ready && !f && model_stall != 32'hFFFF) begin
         model_stall++;
      end
      #1;
   endtask

   // Asynchronous reset with upstream still offering data; outputs must
   // settle to reset values before any clock edge.
   task automatic doReset(input string tag);
      reset   = 1'b1;
      i_valid = 1'b1;
      i_ready = 1'b0;
      i_flush = 1'b0;
      i_data  = 41'h1_2345_6789;
      model_q.delete();
      recv_q.delete();
      model_stall = 0;
      #1;
      checkOutput({tag, ".async"});
      repeat (2) @(posedge clk);
      #1;
      checkOutput({tag, ".held"});
      reset   = 1'b0;
      i_valid = 1'b0;
   endtask

   initial begin
      $display("[TB] flush_pipe_buffer bench start (stats=%0d)", STATS_EN);

      doReset("rst0");

      applyStimulus(1'b1, 41'h1_0000_0004, 1'b0, 1'b0, "first_push");
      checkVal("first_head", 64'(o_data), 64'h1_0000_0004);
      checkVal("first_valid", 64'(o_valid), 64'h1);
      applyStimulus(1'b0, '0, 1'b1, 1'b0, "first_pop");

      recv_q.delete();
      for (int v = 1; v <= 4; v++) begin
         applyStimulus(1'b1, DWIDTH'(v), 1'b0, 1'b0, "fill");
      end
      checkVal("fill_count", 64'(o_count), 64'd4);
      checkVal("fill_ready", 64'(o_ready), 64'd0);
      applyStimulus(1'b1, 41'd5, 1'b0, 1'b0, "hold5");
      applyStimulus(1'b1, 41'd5, 1'b1, 1'b0, "full_pop");
      applyStimulus(1'b1, 41'd5, 1'b1, 1'b0, "push5");
      for (int k = 0; k < 4; k++) begin
         applyStimulus(1'b0, '0, 1'b1, 1'b0, "drain");
      end
      checkVal("drain_n", 64'(recv_q.size()), 64'd5);
      for (int k = 0; k < 5 && k < recv_q.size(); k++) begin
         checkVal("drain_order", 64'(recv_q[k]), 64'(k + 1));
      end

      recv_q.delete();
      for (int v = 0; v < 20; v++) begin
         applyStimulus(1'b1, DWIDTH'(v), 1'b1, 1'b0, "stream");
         checkVal("stream_count", 64'(o_count), 64'd1);
      end
      applyStimulus(1'b0, '0, 1'b1, 1'b0, "stream_tail");
      checkVal("stream_n", 64'(recv_q.size()), 64'd20);
      for (int k = 0; k < 20 && k < recv_q.size(); k++) begin
         checkVal("stream_order", 64'(recv_q[k]), 64'(k));
      end

      for (int v = 10; v < 14; v++) begin
         applyStimulus(1'b1, DWIDTH'(v), 1'b0, 1'b0, "fill2");
      end
      applyStimulus(1'b1, 41'd14, 1'b1, 1'b0, "full_pop2");
      checkVal("full_pop_count", 64'(o_count), 64'd3);
      applyStimulus(1'b1, 41'd14, 1'b0, 1'b0, "late_push");
      checkVal("late_push_count", 64'(o_count), 64'd4);
      for (int k = 0; k < 5; k++) begin
         applyStimulus(1'b0, '0, 1'b1, 1'b0, "drain2");
      end

      for (int v = 20; v < 23; v++) begin
         applyStimulus(1'b1, DWIDTH'(v), 1'b0, 1'b0, "pre_flush");
      end
      applyStimulus(1'b1, 41'd99, 1'b1, 1'b1, "flush");
      i_valid = 1'b0;
      i_flush = 1'b0;
      #1;
      checkVal("post_flush_count", 64'(o_count), 64'd0);
      checkVal("post_flush_valid", 64'(o_valid), 64'd0);
      checkVal("post_flush_ready", 64'(o_ready), 64'd1);
      applyStimulus(1'b1, 41'd7, 1'b0, 1'b0, "push7");
      checkVal("head7", 64'(o_data), 64'd7);
      applyStimulus(1'b1, 41'd8, 1'b1, 1'b1, "flush_a");
      applyStimulus(1'b1, 41'd9, 1'b1, 1'b1, "flush_b");
      applyStimulus(1'b0, '0, 1'b1, 1'b0, "after_flushes");

      doReset("rst_stats");
      for (int v = 30; v < 34; v++) begin
         applyStimulus(1'b1, DWIDTH'(v), 1'b0, 1'b0, "fill3");
      end
      for (int k = 0; k < 10; k++) begin
         applyStimulus(1'b1, 41'd55, 1'b0, 1'b0, "stall");
      end
      checkVal("stall_10", 64'(o_stall_cnt), STATS_EN ? 64'd10 : 64'd0);
      applyStimulus(1'b1, 41'd56, 1'b0, 1'b1, "stall_flush");
      checkVal("stall_keep", 64'(o_stall_cnt), STATS_EN ? 64'd10 : 64'd0);

      for (int k = 0; k < 400; k++) begin
         applyStimulus(1'($urandom_range(0, 3) != 0),
                       {9'($urandom), 32'($urandom)},
                       1'($urandom_range(0, 2) != 0),
                       1'($urandom_range(0, 24) == 0),
                       "rand");
      end

      for (int v = 40; v < 43; v++) begin
         applyStimulus(1'b1, DWIDTH'(v), 1'b0, 1'b0, "pre_rst");
      end
      #2;
      doReset("rst_mid");
      applyStimulus(1'b1, 41'h1_0000_0004, 1'b1, 1'b0, "post_rst_push");
      applyStimulus(1'b0, '0, 1'b1, 1'b0, "post_rst_pop");

      $display("[TB] %0d/%0d checks passed", pass_cnt, check_cnt);
      $finish;
   end

endmodule : tb_flush_pipe_buffer
